// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both uart_rx and uart_rx_fifo.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // One received word plus the error flags that qualify it.
    typedef struct packed {
        logic                      frame_err;
        logic                      parity_err;
        logic [UART_DATA_BITS-1:0] data;
    } rx_entry_t;

    localparam int RX_FLAG_BITS = $bits(rx_entry_t) - UART_DATA_BITS;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with power-of-2 depth and a separate occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        rd_en    = pop & (count_q != '0);
        wr_en    = push & ((count_q != CW'(DEPTH)) | rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-detects data_ready, stores word+flags, tracks sticky overrun.
// Optional macro UART_RX_FIFO_ERR_DROP_EN discards words that arrive with a parity or framing error.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     data_ready,
    input  logic                     parity_err,
    input  logic                     frame_err,
    input  logic                     rd_ready,
    input  logic                     overrun_clr,
    output logic                     rd_valid,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_parity_err,
    output logic                     rd_frame_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    // Same layout as rx_entry_t, widened to this instance's DATA_BITS.
    localparam int ENTRY_W = DATA_BITS + RX_FLAG_BITS;

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic   dr_q, dr_d;
    logic   overrun_q, overrun_d;
    logic   push, push_fifo, pop, err_drop, overflow, empty;
    entry_t wr_entry, rd_entry;

    always_comb begin
        push = data_ready & ~dr_q;
`ifdef UART_RX_FIFO_ERR_DROP_EN
        err_drop = parity_err | frame_err;
`else
        err_drop = 1'b0;
`endif
        push_fifo = push & ~err_drop;
        pop       = rd_valid & rd_ready;
        overflow  = push_fifo & full & ~pop;
        dr_d      = data_ready;
        // A new overflow in the clearing cycle keeps the flag set.
        if (overflow)         overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
        wr_entry = '{frame_err: frame_err, parity_err: parity_err, data: rx_data};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dr_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dr_q      <= dr_d;
            overrun_q <= overrun_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_fifo),
        .wdata  (wr_entry),
        .pop    (pop),
        .rdata  (rd_entry),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign rd_valid      = ~empty;
    assign rd_data       = rd_entry.data;
    assign rd_parity_err = rd_entry.parity_err;
    assign rd_frame_err  = rd_entry.frame_err;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DATA_BITS=8, DEPTH=16); inputs change #1 after posedge, outputs sampled there too.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] rx_data;
    logic       data_ready, parity_err, frame_err, rd_ready, overrun_clr;
    logic       rd_valid, rd_parity_err, rd_frame_err, full, overrun;
    logic [7:0] rd_data;
    logic [4:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .rd_ready      (rd_ready),
        .overrun_clr   (overrun_clr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .count         (count),
        .full          (full),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One data_ready pulse: rise, hold a cycle, fall, settle.
    task automatic push_word(input logic [7:0] d, input logic pe, input logic fe);
        rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1'b1;
        step();
        data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
        step();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
        chk({tag, ".data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (rd_valid) begin
                rd_ready = 1'b1;
                step();
                rd_ready = 1'b0;
            end
        end
        chk("drain.empty", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; rx_data = '0; data_ready = 0; parity_err = 0; frame_err = 0;
        rd_ready = 0; overrun_clr = 0;
        step(); step();
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.valid", 32'(rd_valid), 32'd0);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.overrun", 32'(overrun), 32'd0);
        resetn = 1'b1;
        step();

        // pop on empty is ignored
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("empty_pop.count", 32'(count), 32'd0);

        // long data_ready level -> one entry, visible the cycle after the edge
        rx_data = 8'hA5; data_ready = 1'b1;
        step();
        chk("level.valid_n1", 32'(rd_valid), 32'd1);
        chk("level.data", 32'(rd_data), 32'hA5);
        chk("level.count_n1", 32'(count), 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("level.count_hold", 32'(count), 32'd1);
        data_ready = 1'b0; step();
        pop_chk("level.pop", 8'hA5);
        chk("level.count_after", 32'(count), 32'd0);

        // fill, overflow, ordered drain
        for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.overrun0", 32'(overrun), 32'd0);
        push_word(8'hFF, 1'b0, 1'b0);
        chk("ovf.full", 32'(full), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf.pop%0d", i), 8'(i));
        chk("ovf.empty", 32'(rd_valid), 32'd0);
        chk("ovf.sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("ovf.cleared", 32'(overrun), 32'd0);

        // push+pop on full keeps count, no overrun
        for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0, 1'b0);
        rx_data = 8'h55; data_ready = 1'b1; rd_ready = 1'b1;
        step();
        data_ready = 1'b0; rd_ready = 1'b0;
        chk("pp.count", 32'(count), 32'd16);
        chk("pp.full", 32'(full), 32'd1);
        step();
        chk("pp.overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("pp.pop%0d", i), 8'(i));
        pop_chk("pp.last", 8'h55);
        chk("pp.empty", 32'(rd_valid), 32'd0);

        // error-flagged words
        push_word(8'h3C, 1'b0, 1'b1);
        push_word(8'h12, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
        chk("err.dropped", 32'(rd_valid), 32'd0);
        chk("err.count", 32'(count), 32'd0);
`else
        chk("err.fe_flag", 32'(rd_frame_err), 32'd1);
        chk("err.fe_pflag", 32'(rd_parity_err), 32'd0);
        pop_chk("err.fe", 8'h3C);
        chk("err.pe_flag", 32'(rd_parity_err), 32'd1);
        chk("err.pe_fflag", 32'(rd_frame_err), 32'd0);
        pop_chk("err.pe", 8'h12);
`endif
        drain();

        // overrun_clr colliding with an overflow: overflow wins
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i), 1'b0, 1'b0);
        rx_data = 8'hEE; data_ready = 1'b1; overrun_clr = 1'b1;
        step();
        data_ready = 1'b0; overrun_clr = 1'b0;
        chk("clr_race.overrun", 32'(overrun), 32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("clr_alone.overrun", 32'(overrun), 32'd0);
        drain();

        // reset mid-read flushes everything
        for (int i = 0; i < 5; i++) push_word(8'(8'h90 + i), 1'b0, 1'b0);
        chk("flush.count5", 32'(count), 32'd5);
        rd_ready = 1'b1;
        step();
        #2 resetn = 1'b0;
        #1;
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.valid", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;
        step();
        resetn = 1'b1;
        step();
        push_word(8'h81, 1'b0, 1'b0);
        chk("flush.newcount", 32'(count), 32'd1);
        pop_chk("flush.first", 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
